spi_master_core: RTL and testbench

//   Parametrised SPI master engine behind the SPI register file. Serialises words from a

---
 rtl/spi_master_core.sv | 197 +++++++++++++++++++
 tb/tb_spi_master_core.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_core.sv
// SPI master engine: serialises words from a valid/ready TX stream onto SCK/MOSI,
// returns the received word on a one-cycle RX pulse and owns the chip selects.
// Supports all four CPOL/CPHA modes, LSB-first shifting, multi-word bursts with
// CS held low, a programmable CS-high gap after a burst and a synchronous abort.
module spi_master_core #(
    parameter int DATA_WIDTH    = 8,
    parameter int SLAVE_NUM     = 8,
    parameter int DIVIDER_WIDTH = 32,
    parameter int WAIT_WIDTH    = 32
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     cpol_i,
    input  logic                     cpha_i,
    input  logic                     lsb_first_i,
    input  logic [DIVIDER_WIDTH-1:0] clk_divider_i,
    input  logic [WAIT_WIDTH-1:0]    wait_time_i,
    input  logic [SLAVE_NUM-1:0]     slave_sel_i,
    input  logic                     stop_i,
    input  logic [DATA_WIDTH-1:0]    tx_data_i,
    input  logic                     tx_last_i,
    input  logic                     tx_valid_i,
    output logic                     tx_ready_o,
    output logic [DATA_WIDTH-1:0]    rx_data_o,
    output logic                     rx_valid_o,
    output logic                     busy_o,
    output logic                     sclk_o,
    output logic                     mosi_o,
    input  logic                     miso_i,
    output logic [SLAVE_NUM-1:0]     cs_n_o
);

    // Toggle counter only needs to reach 2*DATA_WIDTH-1; the last toggle resets it.
    localparam int TOG_W = $clog2(2 * DATA_WIDTH);
    localparam logic [TOG_W-1:0] LAST_TOG = TOG_W'(2 * DATA_WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

    state_t                   state_reg;
    logic                     cpol_reg, cpha_reg, lsb_reg, last_reg;
    logic                     wait_word_reg;   // between burst words, SCK parked
    logic [DIVIDER_WIDTH-1:0] div_reg, half_cnt_reg;
    logic [WAIT_WIDTH-1:0]    gap_len_reg, gap_cnt_reg;
    logic [TOG_W-1:0]         tog_cnt_reg;
    logic [DATA_WIDTH-1:0]    tx_sr_reg, rx_sr_reg, rx_data_reg;
    logic                     rx_valid_reg, sclk_reg, mosi_reg;
    logic [SLAVE_NUM-1:0]     cs_n_reg;

    logic                     half_done, leading, sample_now, last_toggle, accept;
    logic                     next_tx_bit, load_lsb, load_cpha, load_first;
    logic [DATA_WIDTH-1:0]    tx_sr_shifted, rx_shifted, load_rest;

    assign half_done   = (half_cnt_reg == div_reg);
    assign leading     = ~tog_cnt_reg[0];               // odd-numbered toggles lead
    assign sample_now  = leading ^ cpha_reg;
    assign last_toggle = (state_reg == S_SHIFT) && !wait_word_reg && half_done &&
                         (tog_cnt_reg == LAST_TOG);

    // Acceptance is combinational so a continuation word can be taken in the very
    // cycle of the final toggle; stop and reset always block it.
    assign tx_ready_o = rstn_i && !stop_i &&
                        ((state_reg == S_IDLE) ||
                         ((state_reg == S_SHIFT) && (wait_word_reg || (last_toggle && !last_reg))));
    assign accept     = tx_valid_i && tx_ready_o;

    assign next_tx_bit   = lsb_reg ? tx_sr_reg[0] : tx_sr_reg[DATA_WIDTH-1];
    assign tx_sr_shifted = lsb_reg ? (tx_sr_reg >> 1) : (tx_sr_reg << 1);
    assign rx_shifted    = lsb_reg ? {miso_i, rx_sr_reg[DATA_WIDTH-1:1]}
                                   : {rx_sr_reg[DATA_WIDTH-2:0], miso_i};

    // The first word of a burst uses the live config; later words the latched one.
    assign load_lsb   = (state_reg == S_IDLE) ? lsb_first_i : lsb_reg;
    assign load_cpha  = (state_reg == S_IDLE) ? cpha_i : cpha_reg;
    assign load_first = load_lsb ? tx_data_i[0] : tx_data_i[DATA_WIDTH-1];
    assign load_rest  = load_lsb ? (tx_data_i >> 1) : (tx_data_i << 1);

    assign rx_data_o  = rx_data_reg;
    assign rx_valid_o = rx_valid_reg;
    assign busy_o     = (state_reg != S_IDLE);
    assign sclk_o     = sclk_reg;
    assign mosi_o     = mosi_reg;
    assign cs_n_o     = cs_n_reg;

    // Main FSM: word framing, SCK generation, shifting and CS control.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_reg     <= S_IDLE;
            cpol_reg      <= 1'b0;
            cpha_reg      <= 1'b0;
            lsb_reg       <= 1'b0;
            last_reg      <= 1'b0;
            wait_word_reg <= 1'b0;
            div_reg       <= '0;
            half_cnt_reg  <= '0;
            gap_len_reg   <= '0;
            gap_cnt_reg   <= '0;
            tog_cnt_reg   <= '0;
            tx_sr_reg     <= '0;
            rx_sr_reg     <= '0;
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            sclk_reg      <= 1'b0;
            mosi_reg      <= 1'b0;
            cs_n_reg      <= '1;
        end else begin
            rx_valid_reg <= 1'b0;
            if ((state_reg != S_IDLE) && stop_i) begin
                // Abort: drop the partial word and skip the gap entirely.
                state_reg     <= S_IDLE;
                cs_n_reg      <= '1;
                sclk_reg      <= cpol_reg;
                wait_word_reg <= 1'b0;
                half_cnt_reg  <= '0;
                tog_cnt_reg   <= '0;
                gap_cnt_reg   <= '0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        sclk_reg <= cpol_i;
                        if (accept) begin
                            cpol_reg     <= cpol_i;
                            cpha_reg     <= cpha_i;
                            lsb_reg      <= lsb_first_i;
                            div_reg      <= clk_divider_i;
                            gap_len_reg  <= wait_time_i;
                            cs_n_reg     <= ~slave_sel_i;
                            last_reg     <= tx_last_i;
                            half_cnt_reg <= '0;
                            tog_cnt_reg  <= '0;
                            tx_sr_reg    <= load_cpha ? tx_data_i : load_rest;
                            if (!load_cpha) mosi_reg <= load_first;
                            state_reg    <= S_SETUP;
                        end
                    end
                    S_SETUP, S_SHIFT: begin
                        if (wait_word_reg) begin
                            if (accept) begin
                                wait_word_reg <= 1'b0;
                                half_cnt_reg  <= '0;
                                last_reg      <= tx_last_i;
                                tx_sr_reg     <= load_cpha ? tx_data_i : load_rest;
                                if (!load_cpha) mosi_reg <= load_first;
                            end
                        end else if (half_done) begin
                            half_cnt_reg <= '0;
                            sclk_reg     <= ~sclk_reg;
                            if (sample_now) rx_sr_reg <= rx_shifted;
                            if (last_toggle) begin
                                tog_cnt_reg  <= '0;
                                rx_data_reg  <= cpha_reg ? rx_shifted : rx_sr_reg;
                                rx_valid_reg <= 1'b1;
                                if (last_reg) begin
                                    state_reg <= S_HOLD;
                                end else if (accept) begin
                                    last_reg  <= tx_last_i;
                                    tx_sr_reg <= load_cpha ? tx_data_i : load_rest;
                                    if (!load_cpha) mosi_reg <= load_first;
                                end else begin
                                    wait_word_reg <= 1'b1;
                                end
                            end else begin
                                tog_cnt_reg <= tog_cnt_reg + TOG_W'(1);
                                state_reg   <= S_SHIFT;
                                if (!sample_now) begin
                                    mosi_reg  <= next_tx_bit;
                                    tx_sr_reg <= tx_sr_shifted;
                                end
                            end
                        end else begin
                            half_cnt_reg <= half_cnt_reg + DIVIDER_WIDTH'(1);
                        end
                    end
                    S_HOLD: begin
                        if (half_done) begin
                            half_cnt_reg <= '0;
                            cs_n_reg     <= '1;
                            gap_cnt_reg  <= '0;
                            state_reg    <= (gap_len_reg == '0) ? S_IDLE : S_GAP;
                        end else begin
                            half_cnt_reg <= half_cnt_reg + DIVIDER_WIDTH'(1);
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt_reg == gap_len_reg - WAIT_WIDTH'(1)) begin
                            gap_cnt_reg <= '0;
                            state_reg   <= S_IDLE;
                        end else begin
                            gap_cnt_reg <= gap_cnt_reg + WAIT_WIDTH'(1);
                        end
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core: an 8-bit instance with a loopback or an
// SPI slave model on MISO, plus a 16-bit LSB-first instance.
module tb_spi_master_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstn;

    // 8-bit instance
    logic        cpol8, cpha8, lsb8, stop8, last8, valid8, loop8;
    logic [31:0] div8, wait8;
    logic [7:0]  sel8, txd8, rxd8, cs8;
    logic        ready8, rxv8, busy8, sclk8, mosi8, miso8;

    // 16-bit instance
    logic        cpol16, cpha16, lsb16, stop16, last16, valid16;
    logic [31:0] div16, wait16;
    logic [1:0]  sel16, cs16;
    logic [15:0] txd16, rxd16;
    logic        ready16, rxv16, busy16, sclk16, mosi16;

    // SPI slave model answering with a fixed word, MSB first
    localparam logic [7:0] SLAVE_WORD = 8'h3C;
    logic [7:0] slv_sr = 8'h00;
    logic       slv_bit = 1'b0, slv_cs_prev = 1'b1, slv_sclk_prev = 1'b0;

    assign miso8 = loop8 ? mosi8 : slv_bit;

    spi_master_core #(.DATA_WIDTH(8), .SLAVE_NUM(8), .DIVIDER_WIDTH(32), .WAIT_WIDTH(32)) dut8 (
        .clk_i(clk), .rstn_i(rstn), .cpol_i(cpol8), .cpha_i(cpha8), .lsb_first_i(lsb8),
        .clk_divider_i(div8), .wait_time_i(wait8), .slave_sel_i(sel8), .stop_i(stop8),
        .tx_data_i(txd8), .tx_last_i(last8), .tx_valid_i(valid8), .tx_ready_o(ready8),
        .rx_data_o(rxd8), .rx_valid_o(rxv8), .busy_o(busy8), .sclk_o(sclk8),
        .mosi_o(mosi8), .miso_i(miso8), .cs_n_o(cs8));

    spi_master_core #(.DATA_WIDTH(16), .SLAVE_NUM(2), .DIVIDER_WIDTH(32), .WAIT_WIDTH(32)) dut16 (
        .clk_i(clk), .rstn_i(rstn), .cpol_i(cpol16), .cpha_i(cpha16), .lsb_first_i(lsb16),
        .clk_divider_i(div16), .wait_time_i(wait16), .slave_sel_i(sel16), .stop_i(stop16),
        .tx_data_i(txd16), .tx_last_i(last16), .tx_valid_i(valid16), .tx_ready_o(ready16),
        .rx_data_o(rxd16), .rx_valid_o(rxv16), .busy_o(busy16), .sclk_o(sclk16),
        .mosi_o(mosi16), .miso_i(mosi16), .cs_n_o(cs16));

    // Slave: CPHA=0 presents bit 7 at CS fall and shifts on trailing edges,
    // CPHA=1 shifts on leading edges.
    always @(cs8[2] or sclk8) begin
        if (cs8[2] !== slv_cs_prev) begin
            slv_cs_prev = cs8[2];
            if (!cs8[2]) begin
                slv_sr = SLAVE_WORD;
                if (!cpha8) begin
                    slv_bit = slv_sr[7];
                    slv_sr  = {slv_sr[6:0], 1'b0};
                end
            end
        end
        if (sclk8 !== slv_sclk_prev) begin
            slv_sclk_prev = sclk8;
            if (!cs8[2] && ((sclk8 !== cpol8) == cpha8)) begin
                slv_bit = slv_sr[7];
                slv_sr  = {slv_sr[6:0], 1'b0};
            end
        end
    end

    int checks = 0, errors = 0, cyc = 0;
    // observation state for dut8
    int         tog8, first8, lastc8, rxn8, rise8, rx_at_rise8, gapn8;
    logic [7:0] cap8, rxlast8, cs_prev8, cs_low8;
    logic [7:0] hist8 [0:7];
    logic       sclk_prev8, sclk_at_rx8;
    // observation state for dut16
    int          tog16, first16, lastc16, rxn16;
    logic [15:0] cap16, rxlast16;
    logic        sclk_prev16;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance to the falling edge and record what both DUTs show.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (rxv8) begin
            if (rxn8 < 8) hist8[rxn8] = rxd8;
            rxn8++;
            rxlast8 = rxd8;
            sclk_at_rx8 = sclk8;
        end
        if (sclk8 !== sclk_prev8) begin
            tog8++;
            if (tog8 == 1) first8 = cyc;
            lastc8 = cyc;
            if (sclk8 !== cpol8) cap8 = {cap8[6:0], mosi8};
        end
        sclk_prev8 = sclk8;
        if (cs8 == 8'hFF && cs_prev8 != 8'hFF) begin
            rise8++;
            rx_at_rise8 = rxn8;
        end
        if (cs8 != 8'hFF) cs_low8 = cs8;
        if (cs8 == 8'hFF && !ready8) gapn8++;
        cs_prev8 = cs8;
        if (rxv16) begin
            rxn16++;
            rxlast16 = rxd16;
        end
        if (sclk16 !== sclk_prev16) begin
            tog16++;
            if (tog16 == 1) first16 = cyc;
            lastc16 = cyc;
            if (sclk16 !== cpol16) cap16 = {cap16[14:0], mosi16};
        end
        sclk_prev16 = sclk16;
    endtask

    task automatic clear();
        tog8 = 0; first8 = 0; lastc8 = 0; rxn8 = 0; rise8 = 0; rx_at_rise8 = 0; gapn8 = 0;
        cap8 = 8'h00; rxlast8 = 8'h00; cs_low8 = 8'hFF; sclk_at_rx8 = 1'bx;
        sclk_prev8 = sclk8; cs_prev8 = cs8;
        for (int i = 0; i < 8; i++) hist8[i] = 8'h00;
        tog16 = 0; first16 = 0; lastc16 = 0; rxn16 = 0; cap16 = 16'h0; rxlast16 = 16'h0;
        sclk_prev16 = sclk16;
    endtask

    task automatic send8(input logic [7:0] d, input logic l, input string tag);
        bit ok = 1'b0;
        txd8 = d; last8 = l; valid8 = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (ready8) begin ok = 1'b1; break; end
            step();
        end
        chk({tag, "_accept"}, 32'(ok), 32'd1);
        if (ok) step();
        valid8 = 1'b0;
    endtask

    task automatic wait_idle8(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (!busy8) begin ok = 1'b1; break; end
        end
        chk({tag, "_idle"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_rx8(input int n, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (rxn8 >= n) begin ok = 1'b1; break; end
            step();
        end
        chk({tag, "_rx_wait"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_tog8(input int n, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (tog8 >= n) begin ok = 1'b1; break; end
            step();
        end
        chk({tag, "_tog_wait"}, 32'(ok), 32'd1);
    endtask

    initial begin
        rstn = 1'b0; loop8 = 1'b1;
        cpol8 = 0; cpha8 = 0; lsb8 = 0; div8 = 1; wait8 = 0; sel8 = 8'h04;
        stop8 = 0; txd8 = 0; last8 = 0; valid8 = 0;
        cpol16 = 0; cpha16 = 0; lsb16 = 1; div16 = 0; wait16 = 0; sel16 = 2'b01;
        stop16 = 0; txd16 = 0; last16 = 1; valid16 = 0;

        // Reset values
        repeat (3) step();
        chk("rst_sclk", 32'(sclk8), 0);
        chk("rst_mosi", 32'(mosi8), 0);
        chk("rst_cs", 32'(cs8), 32'hFF);
        chk("rst_ready", 32'(ready8), 0);
        chk("rst_rxv", 32'(rxv8), 0);
        chk("rst_rxd", 32'(rxd8), 0);
        chk("rst_busy", 32'(busy8), 0);
        chk("rst_cs16", 32'(cs16), 32'h3);
        rstn = 1'b1;
        step();
        chk("idle_ready", 32'(ready8), 1);

        // Test 1: mode 0, div=1, loopback, MSB first
        step(); clear();
        send8(8'hA5, 1'b1, "t1");
        chk("t1_cs", 32'(cs8), 32'hFB);
        chk("t1_mosi_first", 32'(mosi8), 1);
        chk("t1_busy", 32'(busy8), 1);
        wait_idle8("t1");
        chk("t1_toggles", 32'(tog8), 16);
        chk("t1_span", 32'(lastc8 - first8), 30);
        chk("t1_mosi_bits", 32'(cap8), 32'hA5);
        chk("t1_rx_pulses", 32'(rxn8), 1);
        chk("t1_rx", 32'(rxlast8), 32'hA5);
        chk("t1_cs_end", 32'(cs8), 32'hFF);

        // Test 2: modes 1..3 against the slave model
        for (int m = 1; m < 4; m++) begin
            cpol8 = m[1]; cpha8 = m[0]; loop8 = 1'b0;
            step(); clear();
            chk($sformatf("t2_m%0d_idle_sclk", m), 32'(sclk8), 32'(m[1]));
            send8(8'h81, 1'b1, $sformatf("t2_m%0d", m));
            wait_idle8($sformatf("t2_m%0d", m));
            chk($sformatf("t2_m%0d_rx", m), 32'(rxlast8), 32'h3C);
            chk($sformatf("t2_m%0d_hold_sclk", m), 32'(sclk_at_rx8), 32'(m[1]));
            chk($sformatf("t2_m%0d_end_sclk", m), 32'(sclk8), 32'(m[1]));
        end

        // Test 3: three-word burst with a 20-cycle stall before word 2
        cpol8 = 0; cpha8 = 0; loop8 = 1'b1;
        step(); clear();
        send8(8'h11, 1'b0, "t3_w1");
        wait_rx8(1, "t3_w1");
        repeat (20) step();
        chk("t3_ready_stall", 32'(ready8), 1);
        chk("t3_cs_stall", 32'(cs8), 32'hFB);
        chk("t3_sclk_stall", 32'(sclk8), 0);
        send8(8'h22, 1'b0, "t3_w2");
        send8(8'h33, 1'b1, "t3_w3");
        wait_idle8("t3");
        chk("t3_rx_count", 32'(rxn8), 3);
        chk("t3_rx0", 32'(hist8[0]), 32'h11);
        chk("t3_rx1", 32'(hist8[1]), 32'h22);
        chk("t3_rx2", 32'(hist8[2]), 32'h33);
        chk("t3_cs_rises", 32'(rise8), 1);
        chk("t3_rx_before_rise", 32'(rx_at_rise8), 3);

        // Test 4: 16-bit LSB first, div=0
        step(); clear();
        txd16 = 16'h0001; valid16 = 1'b1;
        chk("t4_ready", 32'(ready16), 1);
        step();
        valid16 = 1'b0;
        chk("t4_mosi_first", 32'(mosi16), 1);
        begin
            bit ok16 = 1'b0;
            for (int i = 0; i < 200; i++) begin
                step();
                if (!busy16) begin ok16 = 1'b1; break; end
            end
            chk("t4_idle", 32'(ok16), 1);
        end
        chk("t4_mosi_bits", 32'(cap16), 32'h8000);
        chk("t4_toggles", 32'(tog16), 32);
        chk("t4_span", 32'(lastc16 - first16), 31);
        chk("t4_rx", 32'(rxlast16), 32'h0001);
        chk("t4_rx_pulses", 32'(rxn16), 1);

        // Test 5: CS-high gap of 10 cycles, multi-hot select
        wait8 = 10; sel8 = 8'h81;
        step(); clear();
        send8(8'hC3, 1'b1, "t5");
        chk("t5_cs", 32'(cs8), 32'h7E);
        wait_idle8("t5");
        chk("t5_gap_cycles", 32'(gapn8), 10);
        chk("t5_rx", 32'(rxlast8), 32'hC3);
        chk("t5_ready_after", 32'(ready8), 1);

        // Test 6a: stop mid-word
        wait8 = 0; sel8 = 8'h04;
        step(); clear();
        send8(8'h5A, 1'b1, "t6a");
        wait_tog8(5, "t6a");
        chk("t6a_sclk_mid", 32'(sclk8), 1);
        stop8 = 1'b1;
        step();
        chk("t6a_cs", 32'(cs8), 32'hFF);
        chk("t6a_busy", 32'(busy8), 0);
        chk("t6a_sclk", 32'(sclk8), 0);
        chk("t6a_ready_stop", 32'(ready8), 0);
        stop8 = 1'b0;
        step();
        chk("t6a_ready", 32'(ready8), 1);
        repeat (40) step();
        chk("t6a_no_rx", 32'(rxn8), 0);

        // Test 6b: stop coincident with the final toggle
        clear();
        send8(8'h96, 1'b1, "t6b");
        wait_tog8(15, "t6b");
        step();
        stop8 = 1'b1;
        step();
        stop8 = 1'b0;
        chk("t6b_busy", 32'(busy8), 0);
        chk("t6b_cs", 32'(cs8), 32'hFF);
        repeat (10) step();
        chk("t6b_no_rx", 32'(rxn8), 0);

        // Test 6c: reset mid-word in mode 2
        cpol8 = 1'b1;
        step(); clear();
        send8(8'hE7, 1'b1, "t6c");
        wait_tog8(4, "t6c");
        chk("t6c_mosi_mid", 32'(mosi8), 1);
        rstn = 1'b0;
        step();
        chk("t6c_sclk", 32'(sclk8), 0);
        chk("t6c_mosi", 32'(mosi8), 0);
        chk("t6c_cs", 32'(cs8), 32'hFF);
        chk("t6c_ready", 32'(ready8), 0);
        chk("t6c_rxv", 32'(rxv8), 0);
        chk("t6c_rxd", 32'(rxd8), 0);
        chk("t6c_busy", 32'(busy8), 0);
        rstn = 1'b1;
        repeat (40) step();
        chk("t6c_no_rx", 32'(rxn8), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
